// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch requester (F)
// and the load/store requester (D). Ties go round-robin, and a watchdog bounds
// every RAM access. All outputs are registered.

`ifndef RAM_CAPACITY
`define RAM_CAPACITY 65536
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif

module mem_arbiter #(
    parameter int ADDR_W  = $clog2(`RAM_CAPACITY),
    parameter int DATA_W  = 8 * `WORD_SIZE,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    // instruction-fetch requester
    input  logic              F_Req,
    input  logic [ADDR_W-1:0] F_Addr,
    input  logic              F_We,
    input  logic [DATA_W-1:0] F_Wdata,
    output logic [DATA_W-1:0] F_Rdata,
    output logic              F_Ack,
    output logic              F_Err,
    // load/store requester
    input  logic              D_Req,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic              D_We,
    input  logic [DATA_W-1:0] D_Wdata,
    output logic [DATA_W-1:0] D_Rdata,
    output logic              D_Ack,
    output logic              D_Err,
    // RAM port
    output logic [ADDR_W-1:0] Addr,
    output logic              Cs,
    output logic              We,
    output logic [DATA_W-1:0] Wdata,
    input  logic [DATA_W-1:0] Rdata,
    input  logic              Ack,
    // status
    output logic              Busy
);

    // Timer only has to reach TIMEOUT-1; a disabled watchdog still needs one bit.
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        SEL_F = 1'b0,
        SEL_D = 1'b1
    } sel_t;

    state_t           state;
    state_t           state_next;
    sel_t             owner;
    sel_t             last;
    logic [TMR_W-1:0] timer;

    logic             grant;
    sel_t             grant_sel;
    logic             ram_ok;
    logic             ram_err;
    logic             timed_out;

    assign timed_out = (TIMEOUT != 0) && (timer == TMR_LAST);

    // State register.
    // NOTE: sequential logic uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant in IDLE, leave ACCESS on RAM Ack or watchdog, RESP lasts one cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (ram_ok || ram_err) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: who is granted, and how the current access ends (Ack beats timeout).
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        grant     = 1'b0;
        grant_sel = SEL_F;
        ram_ok    = 1'b0;
        ram_err   = 1'b0;
        if (state == IDLE) begin
            if (F_Req && D_Req) begin
                grant     = 1'b1;
                grant_sel = (last == SEL_D) ? SEL_F : SEL_D;
            end else if (F_Req) begin
                grant     = 1'b1;
                grant_sel = SEL_F;
            end else if (D_Req) begin
                grant     = 1'b1;
                grant_sel = SEL_D;
            end
        end
        if (state == ACCESS) begin
            if (Ack) begin
                ram_ok = 1'b1;
            end else if (timed_out) begin
                ram_err = 1'b1;
            end
        end
    end

    // Registered datapath: request latches, RAM strobes, completion pulses and read data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            owner   <= SEL_F;
            last    <= SEL_D;
            timer   <= '0;
            Addr    <= '0;
            We      <= 1'b0;
            Wdata   <= '0;
            Cs      <= 1'b0;
            Busy    <= 1'b0;
            F_Ack   <= 1'b0;
            F_Err   <= 1'b0;
            D_Ack   <= 1'b0;
            D_Err   <= 1'b0;
            F_Rdata <= '0;
            D_Rdata <= '0;
        end else begin
            Cs    <= (state_next == ACCESS);
            Busy  <= (state_next != IDLE);
            F_Ack <= ram_ok  && (owner == SEL_F);
            F_Err <= ram_err && (owner == SEL_F);
            D_Ack <= ram_ok  && (owner == SEL_D);
            D_Err <= ram_err && (owner == SEL_D);

            if (grant) begin
                owner <= grant_sel;
                timer <= '0;
                if (grant_sel == SEL_D) begin
                    Addr  <= D_Addr;
                    We    <= D_We;
                    Wdata <= D_Wdata;
                end else begin
                    Addr  <= F_Addr;
                    We    <= F_We;
                    Wdata <= F_Wdata;
                end
            end else if ((state == ACCESS) && (TIMEOUT != 0)) begin
                timer <= timer + TMR_W'(1);
            end

            // Write strobe only spans ACCESS; address and data simply hold.
            if (ram_ok || ram_err) begin
                We <= 1'b0;
            end

            // Only a successful read updates the owner's read data.
            if (ram_ok && !We) begin
                if (owner == SEL_D) begin
                    D_Rdata <= Rdata;
                end else begin
                    F_Rdata <= Rdata;
                end
            end

            if (state == RESP) begin
                last <= owner;
            end
        end
    end

endmodule
